// File: rtl/tdm_demux.sv
// Purpose: serial TDM receiver; splits NCH slots of W bits per frame onto parallel channel outputs.
// Latency: a slot word appears on DOUT with its VALID strobe one cycle after the edge that samples its LSB.
// Backpressure: none; consumers must take DOUT while VALID is high or keep their own copy.
module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               DIN,
    input  logic               FS,
    output logic [NCH*W-1:0]   DOUT,
    output logic [NCH-1:0]     VALID,
    output logic               FRAME_DONE,
    output logic               SYNC_ERR,
    output logic               LOCKED
);

    localparam int BCW = (W   > 1) ? $clog2(W)   : 1;
    localparam int SCW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [BCW-1:0] BC_LAST = BCW'(W - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(NCH - 1);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [0:0]     state;
    logic [W-2:0]   shreg;
    logic [BCW-1:0] bc;
    logic [SCW-1:0] sc;

    logic [W-1:0]   word;
    logic           recv;
    logic           frame_chk;
    logic           frame_lost;
    logic           early_fs;
    logic           word_done;

    assign word = {shreg, DIN};
    assign recv = (state == ST_RECV);

    // bc==0 && sc==0 only occurs in RECV right after a frame wrapped, so FS is mandatory there.
    assign frame_chk  = recv && (bc == '0) && (sc == '0);
    assign frame_lost = frame_chk && !FS;
    assign early_fs   = recv && !frame_chk && FS;

    // A realigning FS on the LSB edge swallows the word, hence the !FS term.
    assign word_done  = recv && !frame_chk && !FS && (bc == BC_LAST);

    assign LOCKED = recv;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_HUNT;
            shreg <= '0;
            bc    <= '0;
            sc    <= '0;
        end else if (FS) begin
            state <= ST_RECV;
            shreg <= word[W-2:0];
            bc    <= BCW'(1);
            sc    <= '0;
        end else if (frame_lost) begin
            state <= ST_HUNT;
            bc    <= '0;
            sc    <= '0;
        end else if (recv) begin
            shreg <= word[W-2:0];
            if (word_done) begin
                bc <= '0;
                sc <= (sc == SC_LAST) ? '0 : sc + SCW'(1);
            end else begin
                bc <= bc + BCW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            VALID      <= '0;
            FRAME_DONE <= 1'b0;
            SYNC_ERR   <= 1'b0;
        end else begin
            VALID      <= word_done ? (NCH'(1) << sc) : '0;
            FRAME_DONE <= word_done && (sc == SC_LAST);
            SYNC_ERR   <= frame_lost || early_fs;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DOUT <= '0;
        end else if (word_done) begin
            for (int k = 0; k < NCH; k++) begin
                if (sc == SCW'(k)) begin
                    DOUT[k*W +: W] <= word;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a 4x8 instance for framing behaviour and a 2x4 instance for the parameter variant.
module tb_tdm_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fs_a, din_a, fs_b, din_b;
    logic [31:0] dout_a;
    logic [3:0]  valid_a;
    logic        fd_a, se_a, lk_a;
    logic [7:0]  dout_b;
    logic [1:0]  valid_b;
    logic        fd_b, se_b, lk_b;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int fd_prev = -1;
    int fd_last = -1;

    tdm_demux #(.NCH(4), .W(8)) dut_a (
        .CLK(clk), .RST_N(rst_n), .DIN(din_a), .FS(fs_a),
        .DOUT(dout_a), .VALID(valid_a), .FRAME_DONE(fd_a), .SYNC_ERR(se_a), .LOCKED(lk_a)
    );

    tdm_demux #(.NCH(2), .W(4)) dut_b (
        .CLK(clk), .RST_N(rst_n), .DIN(din_b), .FS(fs_b),
        .DOUT(dout_b), .VALID(valid_b), .FRAME_DONE(fd_b), .SYNC_ERR(se_b), .LOCKED(lk_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic f, input logic d);
        fs_a  = f;
        din_a = d;
        @(posedge clk);
        #1;
        cyc++;
        if (fd_a === 1'b1) begin
            fd_prev = fd_last;
            fd_last = cyc;
        end
    endtask

    task automatic step_b(input logic f, input logic d);
        fs_b  = f;
        din_b = d;
        @(posedge clk);
        #1;
    endtask

    // Sends bits b0..b1-1 of one slot word (MSB first); FS optionally on the first bit sent.
    task automatic send_word(input int slot, input logic [7:0] data, input int b0, input int b1,
                             input logic fs_first, input logic err_first);
        for (int b = b0; b < b1; b++) begin
            step((b == b0) ? fs_first : 1'b0, data[7-b]);
            chk($sformatf("valid s%0d b%0d", slot, b), 64'(valid_a),
                (b == 7) ? (64'd1 << slot) : 64'd0);
            chk($sformatf("frame_done s%0d b%0d", slot, b), 64'(fd_a),
                64'((b == 7) && (slot == 3)));
            chk($sformatf("sync_err s%0d b%0d", slot, b), 64'(se_a),
                (b == b0) ? 64'(err_first) : 64'd0);
            chk($sformatf("locked s%0d b%0d", slot, b), 64'(lk_a), 64'd1);
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input logic err_first);
        for (int s = 0; s < 4; s++) begin
            send_word(s, w[s*8 +: 8], 0, 8, (s == 0), (s == 0) ? err_first : 1'b0);
        end
    endtask

    initial begin
        logic [7:0] wb;
        rst_n = 1'b0;
        fs_a = 1'b0; din_a = 1'b0; fs_b = 1'b0; din_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset dout", 64'(dout_a), 64'd0);
        chk("reset valid", 64'(valid_a), 64'd0);
        chk("reset frame_done", 64'(fd_a), 64'd0);
        chk("reset sync_err", 64'(se_a), 64'd0);
        chk("reset locked", 64'(lk_a), 64'd0);
        chk("reset dout_b", 64'(dout_b), 64'd0);
        rst_n = 1'b1;

        // Hunting: DIN activity without FS must be ignored.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, i[0]);
            chk("hunt valid", 64'(valid_a), 64'd0);
            chk("hunt locked", 64'(lk_a), 64'd0);
        end

        // Clean frame, then a back-to-back frame.
        send_frame(32'h00FF3CA5, 1'b0);
        chk("frame1 dout", 64'(dout_a), 64'h00FF3CA5);
        send_frame(32'h04030201, 1'b0);
        chk("frame2 dout", 64'(dout_a), 64'h04030201);
        chk("frame_done spacing", 64'(fd_last - fd_prev), 64'd32);

        // Missing FS after a completed frame.
        step(1'b0, 1'b1);
        chk("missing fs sync_err", 64'(se_a), 64'd1);
        chk("missing fs locked", 64'(lk_a), 64'd0);
        chk("missing fs valid", 64'(valid_a), 64'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, ~i[0]);
            chk("post-loss sync_err", 64'(se_a), 64'd0);
            chk("post-loss valid", 64'(valid_a), 64'd0);
            chk("post-loss locked", 64'(lk_a), 64'd0);
        end
        chk("post-loss dout", 64'(dout_a), 64'h04030201);

        send_frame(32'h00FF3CA5, 1'b0);
        chk("relock dout", 64'(dout_a), 64'h00FF3CA5);

        // Early FS at bit 3 of slot 1.
        send_word(0, 8'h11, 0, 8, 1'b1, 1'b0);
        send_word(1, 8'h66, 0, 3, 1'b0, 1'b0);
        chk("pre-early dout", 64'(dout_a), 64'h00FF3C11);
        send_frame(32'hDDCCBBAA, 1'b1);
        chk("realigned dout", 64'(dout_a), 64'hDDCCBBAA);

        // Early FS on the LSB edge of slot 0: the word must be dropped.
        send_word(0, 8'h77, 0, 7, 1'b1, 1'b0);
        send_word(0, 8'h11, 0, 1, 1'b1, 1'b1);
        chk("same-edge dout held", 64'(dout_a), 64'hDDCCBBAA);
        send_word(0, 8'h11, 1, 8, 1'b0, 1'b0);
        send_word(1, 8'h22, 0, 8, 1'b0, 1'b0);
        send_word(2, 8'h33, 0, 8, 1'b0, 1'b0);
        send_word(3, 8'h44, 0, 8, 1'b0, 1'b0);
        chk("same-edge next frame dout", 64'(dout_a), 64'h44332211);

        // Asynchronous reset during bit 5 of slot 2.
        send_word(0, 8'h12, 0, 8, 1'b1, 1'b0);
        send_word(1, 8'h34, 0, 8, 1'b0, 1'b0);
        send_word(2, 8'h56, 0, 5, 1'b0, 1'b0);
        fs_a  = 1'b0;
        din_a = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset dout", 64'(dout_a), 64'd0);
        chk("async reset valid", 64'(valid_a), 64'd0);
        chk("async reset frame_done", 64'(fd_a), 64'd0);
        chk("async reset sync_err", 64'(se_a), 64'd0);
        chk("async reset locked", 64'(lk_a), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i[0]);
            chk("post-reset valid", 64'(valid_a), 64'd0);
            chk("post-reset locked", 64'(lk_a), 64'd0);
        end
        chk("post-reset dout", 64'(dout_a), 64'd0);
        send_frame(32'h87654321, 1'b0);
        chk("post-reset frame dout", 64'(dout_a), 64'h87654321);

        // Parameter variant: NCH=2, W=4, slots A then 5.
        wb = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            step_b(i == 0, wb[(i / 4) * 4 + 3 - (i % 4)]);
            chk($sformatf("b valid bit%0d", i), 64'(valid_b),
                (i == 3) ? 64'd1 : ((i == 7) ? 64'd2 : 64'd0));
            chk($sformatf("b frame_done bit%0d", i), 64'(fd_b), 64'(i == 7));
            chk($sformatf("b sync_err bit%0d", i), 64'(se_b), 64'd0);
            chk($sformatf("b locked bit%0d", i), 64'(lk_b), 64'd1);
        end
        chk("b dout", 64'(dout_b), 64'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receiving end of a serial TDM link.
- Takes one serial bit stream carrying NCH fixed-width slots per frame, delimited by a frame-sync pulse, and routes each slot's word to its own parallel output channel with a per-channel valid strobe.
- Sits between a serial line and per-channel consumers; the companion of our selector/multiplexer blocks, in the opposite direction.

Parameters:
- NCH, 4, number of slots (channels) per frame; at least 2.
- W, 8, bits per slot word; at least 2.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DIN  input  1  serial data, MSB of each slot first, one bit per clock.
- FS  input  1  frame sync; high for one cycle, coincident with the MSB of slot 0.
- DOUT  output  NCH*W  channel words; slot k occupies bits [k*W+W-1 : k*W].
- VALID  output  NCH  one-cycle strobe; VALID[k] high means the DOUT slice for slot k was just updated.
- FRAME_DONE  output  1  one-cycle strobe when the last slot of a frame has been delivered.
- SYNC_ERR  output  1  one-cycle strobe on a framing violation.
- LOCKED  output  1  high while in RECV.

Behaviour:
- Reset (RST_N low, asynchronous):
  - DOUT=0, VALID=0, FRAME_DONE=0, SYNC_ERR=0, LOCKED=0.
  - Shift register and the bit and slot counters cleared; state=HUNT.
  - Reset mid-frame discards the partial word; DOUT is not updated for it.
- States:
  - HUNT: DIN is ignored until an edge samples FS=1. That edge captures DIN as bit 0 of slot 0, sets bc=1 and sc=0, and moves to RECV.
  - RECV: each edge shifts DIN into the shift register (MSB first) and increments bc.
- Word completion: on an edge with bc==W-1 in RECV:
  - {shreg[W-2:0],DIN} is written to the DOUT slice sc.
  - VALID[sc] is 1 for the next cycle only.
  - bc returns to 0 and sc increments.
  - Latency: the word is visible on DOUT one cycle after the edge that samples its LSB.
  - Other DOUT slices hold their values.
- End of frame: completion of slot NCH-1 also pulses FRAME_DONE in the same cycle as VALID[NCH-1]; sc wraps to 0.
- Frame check: the edge after frame completion must sample FS=1.
  - FS=1: new frame continues seamlessly, no gap cycles; that bit is bit 0 of slot 0.
  - FS=0: pulse SYNC_ERR, go to HUNT, LOCKED falls, the bit is discarded.
- Early FS: FS=1 in RECV at any position other than bit 0 of slot 0 pulses SYNC_ERR.
  - Realign immediately: the bit becomes bit 0 of slot 0.
  - The partial word is discarded; no VALID is raised for it.
  - State stays RECV.
- Same-edge events: if the early-FS edge is also a word-completion edge (bc==W-1), realignment wins; no VALID and no DOUT update for that word.
- Strobe overlap: VALID is one-hot or zero, never more than one bit high. FRAME_DONE and SYNC_ERR are never high together.
- No backpressure: consumers must sample DOUT while VALID is high or hold their own copy. DOUT is stable until the same slot is next rewritten.

Test Plan:
1. Clean frame: W=8, NCH=4; FS with slot bytes A5, 3C, FF, 00 serialized MSB first → VALID[0..3] pulse at cycles 8, 16, 24, 32 after the FS edge; DOUT=00FF3CA5 (slot 3 in the high byte); FRAME_DONE with VALID[3]; LOCKED=1.
2. Back-to-back frames: second frame 01, 02, 03, 04 with FS immediately after the last bit → no SYNC_ERR; final DOUT=04030201; two FRAME_DONE pulses exactly 32 cycles apart.
3. Missing FS: after frame 1, send 8 bits with FS=0 → SYNC_ERR pulses once; LOCKED=0; DOUT remains 00FF3CA5; no VALID until the next FS.
4. Early FS: FS re-asserted at bit 3 of slot 1 → SYNC_ERR pulse; no VALID[1]; the following 32 bits deliver a full frame aligned to the new FS.
5. Reset mid-frame: RST_N low during bit 5 of slot 2 → all outputs 0 immediately, without waiting for a clock edge; after release, DIN toggling without FS produces no VALID; the next FS frame decodes correctly.
6. Parameter variant: NCH=2, W=4; slots A, 5 → DOUT=5A; VALID[0] at cycle 4, VALID[1] and FRAME_DONE at cycle 8.
